// File: rtl/led_pwm_stage.sv
// Two-channel LED pad stage: shared PWM brightness and optional blink gate.
// Define LED_BLINK_EN to build the blink counter and phase gate.
module led_pwm_stage #(
  parameter int PWM_W       = 8,
  parameter int PRESCALE    = 12000,
  parameter int BLINK_TICKS = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_a,
  input  logic             in_b,
  input  logic [PWM_W-1:0] duty,
  input  logic             blink,
  output logic             led_a,
  output logic             led_b,
  output logic             tick
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_q;
  logic             wrap;
  logic             pwm_last;
  logic             pwm_on;
  logic             gate;

  assign wrap     = (pre_cnt == PRE_MAX);
  assign pwm_last = &pwm_cnt;
  assign pwm_on   = (pwm_cnt < duty_q);

`ifdef LED_BLINK_EN
  localparam int BLK_W =
    (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX =
    BLK_W'(BLINK_TICKS - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             phase;

  // Runs even when blink is low so the phase stays aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == BLK_MAX) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign gate = blink ? phase : 1'b1;
`else
  logic unused_blink;

  assign unused_blink = blink;
  assign gate         = 1'b1;
`endif

  // Duty is shadowed so a period is never truncated or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
      pwm_cnt <= '0;
      duty_q  <= '0;
      led_a   <= 1'b0;
      led_b   <= 1'b0;
    end else begin
      pre_cnt <= wrap ? '0 : pre_cnt + 1'b1;
      tick    <= wrap;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_last) begin
        duty_q <= duty;
      end
      led_a <= in_a & pwm_on & gate;
      led_b <= in_b & pwm_on & gate;
    end
  end

endmodule

// File: tb/tb_led_pwm_stage.sv
// Bench for led_pwm_stage: vector table, corner sequences, random run.
// Honours LED_BLINK_EN the same way the design does.
module tb_led_pwm_stage;

  localparam int PW   = 4;
  localparam int PS   = 4;
  localparam int BT   = 3;
  localparam int PER  = 1 << PW;
  localparam int HALF = PS * BT;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_a  = 1'b0;
  logic          in_b  = 1'b0;
  logic          blink = 1'b0;
  logic [PW-1:0] duty  = '0;
  logic          led_a;
  logic          led_b;
  logic          tick;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since reset release and shadowed duty.
  int   n  = 0;
  int   dq = 0;
  logic ea, eb, et;

  int on_a, on_b, run, max_run;

  typedef struct {
    logic          a;
    logic          b;
    logic [PW-1:0] d;
    int            exp_a;
    int            exp_b;
  } vec_t;

  vec_t tbl[6];

  led_pwm_stage #(
    .PWM_W      (PW),
    .PRESCALE   (PS),
    .BLINK_TICKS(BT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in_a (in_a),
    .in_b (in_b),
    .duty (duty),
    .blink(blink),
    .led_a(led_a),
    .led_b(led_b),
    .tick (tick)
  );

  always #5 clk = ~clk;

  function automatic bit phase_at(input int k);
    return ((k / HALF) % 2) == 0;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    int pc;
    bit g;
    bit on;
    pc = n % PER;
`ifdef LED_BLINK_EN
    g = blink ? phase_at(n) : 1'b1;
`else
    g = 1'b1;
`endif
    on = (pc < dq);
    ea = in_a & on & g;
    eb = in_b & on & g;
    if (pc == PER - 1) dq = int'(duty);
    @(posedge clk);
    n++;
    et = (n % PS) == 0;
    #1;
    chk("led_a", led_a, ea);
    chk("led_b", led_b, eb);
    chk("tick", tick, et);
    if (led_a === 1'b1) begin
      on_a++;
      run = 0;
    end else begin
      run++;
      if (run > max_run) max_run = run;
    end
    if (led_b === 1'b1) on_b++;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic clr();
    on_a    = 0;
    on_b    = 0;
    run     = 0;
    max_run = 0;
  endtask

  task automatic align();
    for (int i = 0; i < PER && (n % PER) != 0; i++) step();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd5,  5,  0};
    tbl[1] = '{1'b0, 1'b1, 4'd9,  0,  9};
    tbl[2] = '{1'b1, 1'b1, 4'd15, 15, 15};
    tbl[3] = '{1'b1, 1'b1, 4'd0,  0,  0};
    tbl[4] = '{1'b1, 1'b1, 4'd1,  1,  1};
    tbl[5] = '{1'b1, 1'b0, 4'd8,  8,  0};

    // Reset held with everything requested on.
    in_a = 1'b1;
    in_b = 1'b1;
    duty = 4'd15;
    #3;
    chk("rst_led_a", led_a, 1'b0);
    chk("rst_led_b", led_b, 1'b0);
    chk("rst_tick", tick, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_a", led_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    steps(PER);
    chk("post_rst_on", on_a, 0);
    step();
    chk("first_load", led_a, 1'b1);

    // Steady-state on-counts per period.
    blink = 1'b0;
    foreach (tbl[i]) begin
      in_a = tbl[i].a;
      in_b = tbl[i].b;
      duty = tbl[i].d;
      steps(PER + 2);
      clr();
      steps(PER);
      chk($sformatf("tbl%0d_on_a", i), on_a, tbl[i].exp_a);
      chk($sformatf("tbl%0d_on_b", i), on_b, tbl[i].exp_b);
    end

    // Mid-period duty change only lands next period.
    in_a = 1'b1;
    in_b = 1'b0;
    duty = 4'd5;
    steps(PER + 2);
    align();
    clr();
    for (int i = 0; i < PER; i++) begin
      if ((n % PER) == 3) duty = 4'd12;
      step();
    end
    chk("chg_cur_on", on_a, 5);
    clr();
    steps(PER);
    chk("chg_next_on", on_a, 12);
    duty = 4'd0;
    steps(PER + 2);
    clr();
    steps(2 * PER);
    chk("duty0_on", on_a, 0);

    // Blink gating, then blink released.
    duty  = 4'd15;
    blink = 1'b1;
    steps(PER + 2);
    clr();
    steps(4 * HALF);
`ifdef LED_BLINK_EN
    chk("blink_dark", max_run >= HALF, 1'b1);
`else
    chk("blink_dark", max_run, 1);
`endif
    blink = 1'b0;
    steps(2);
    clr();
    steps(4 * HALF);
    chk("noblink_dark", max_run, 1);

    // Asynchronous reset between edges while lit.
    for (int i = 0; i < 2 * PER && led_a !== 1'b1; i++)
      step();
    chk("pre_async_a", led_a, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_led_a", led_a, 1'b0);
    chk("async_tick", tick, 1'b0);
    n  = 0;
    dq = 0;
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    steps(PER);
    chk("post_async_on", on_a, 0);

    // Random stimulus against the reference.
    for (int i = 0; i < 500; i++) begin
      in_a = 1'($urandom);
      in_b = 1'($urandom);
      if ($urandom_range(0, 15) == 0) blink = ~blink;
      if ($urandom_range(0, 7) == 0)
        duty = PW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_stage.md
# led_pwm_stage

Two-channel LED output stage that sits directly downstream of the constant-level driver blocks and consumes their 1-bit levels. It adds PWM brightness control and an optional blink gate before the levels reach the LED pins. Each input level is ANDed with a shared PWM waveform and a shared blink phase, then registered onto the pads. All timing is derived from the single board clock.

## Interface
- PWM_W, 8, width of PWM counter and duty input; period = 2^PWM_W clk cycles
- PRESCALE, 12000, clk cycles per blink tick (1 ms at 12 MHz); must be ≥ 2
- BLINK_TICKS, 500, ticks per blink half-period; must be ≥ 1

- clk  in  1  board clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_a  in  1  channel A level from upstream driver (1 = LED requested on)
- in_b  in  1  channel B level from upstream driver
- duty  in  PWM_W  brightness; on-cycles per PWM period
- blink  in  1  1 = gate both channels with blink phase
- led_a  out  1  channel A pad drive, registered
- led_b  out  1  channel B pad drive, registered
- tick  out  1  one-cycle pulse at each prescaler wrap

## Operation
- Reset is asynchronous and active-low: clk is the only clock; rst_n low forces all state to reset values immediately, independent of clk.
- Prescaler: pre_cnt counts 0..PRESCALE-1, then wraps to 0; tick is registered high for the one cycle after pre_cnt == PRESCALE-1.
- PWM: pwm_cnt is a free-running PWM_W-bit counter, incremented every clk, wrapping naturally from all-ones to 0.
- Duty shadow: duty_q loads duty only in the cycle where pwm_cnt == all-ones, so a new duty value takes effect at the start of the next period. A mid-period duty change never produces a truncated or extended pulse.
- pwm_on = (pwm_cnt < duty_q), unsigned compare. duty_q = 0 means never on; all-ones means on 2^PWM_W−1 of 2^PWM_W cycles.
- Blink: blink_cnt counts ticks 0..BLINK_TICKS-1. On the tick where blink_cnt == BLINK_TICKS-1, it wraps and phase toggles.
- Blink counters always run, regardless of the blink input. This keeps the phase aligned when blink is toggled.
- gate = blink ? phase : 1.
- led_x next = in_x & pwm_on & gate, registered.
- Channels are independent in their level but share pwm_cnt, duty_q and phase.

## Timing
- Reset values: led_a = 0, led_b = 0, tick = 0, pre_cnt = 0, pwm_cnt = 0, duty_q = 0, blink_cnt = 0, phase = 1 (so blink starts in the lit phase).
- First cycle after reset release: pwm_cnt = 0, duty_q = 0, so LEDs stay off until duty_q is loaded. The first load happens at the first pwm_cnt == all-ones, i.e. 2^PWM_W − 1 cycles after release.
- Latency from in_x, blink or phase to led_x: 1 clk.
- Latency from duty to led_x: up to 2^PWM_W cycles (shadow load), then 1 clk.
- tick period: PRESCALE clk cycles exactly.
- Phase half-period: PRESCALE·BLINK_TICKS clk cycles.
- Simultaneous wraps (prescaler wrap, blink wrap and PWM wrap in the same cycle) are all applied in that cycle, with no priority interaction.
- rst_n asserted mid-period: outputs drop to 0 asynchronously. No partial state survives.

## Configuration
- LED_BLINK_EN defined: blink_cnt, phase and the blink input are active as described above.
- LED_BLINK_EN undefined: blink_cnt and phase are not instantiated, gate is constant 1, and the blink input is ignored. The prescaler and tick output remain.

## Test plan
Bench parameters: PWM_W = 4, PRESCALE = 4, BLINK_TICKS = 3.
- Reset: hold rst_n = 0 with in_a = in_b = 1 and duty = 15 -> led_a = led_b = tick = 0. Release; outputs stay 0 for the first 16 cycles, until duty_q loads.
- PWM duty: in_a = 1, in_b = 0, duty = 5, blink = 0 -> in steady state led_a is high exactly 5 of every 16 cycles, contiguous from pwm_cnt 0..4 plus 1 clk. led_b stays 0.
- Duty change mid-period: change duty 5 -> 12 while pwm_cnt = 3 -> the current period still shows 5 on-cycles; the next period shows 12. duty = 0 -> led_a never high.
- Blink (LED_BLINK_EN defined): duty = 15, blink = 1 -> tick every 4 cycles; led_a alternates 12-cycle lit and 12-cycle dark windows, starting lit. With blink = 0 -> no dark windows.
- Async reset mid-run: pull rst_n low between clk edges while led_a = 1 -> led_a = 0 before the next edge. After release, behaviour matches the reset scenario.
- LED_BLINK_EN undefined: blink = 1, duty = 15 -> led_a shows the PWM pattern only, with no dark windows.
